// File: rtl/microondas_pkg.sv
// Shared constants for the microwave cooking controller: state encodings,
// digit limits and a BCD validity helper.
package microondas_pkg;

  localparam int STATE_W        = 3;
  localparam int MAX_DIGITS_DEF = 3;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_SET   = 3'd1;
  localparam logic [STATE_W-1:0] ST_COOK  = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/microondas_ctrl_if.sv
// Button/door/timer signal bundle between the panel, the controller and the
// timer datapath. The controller uses the slave side.
interface microondas_ctrl_if;
  import microondas_pkg::*;

  logic               key_valid;
  logic [3:0]         key_digit;
  logic               start;
  logic               stop;
  logic               door_closed;
  logic               tmr_zero;
  logic [3:0]         tmr_digit;
  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_clr;
  logic               mag_on;
  logic               lamp;
  logic               beep;
  logic [STATE_W-1:0] state_o;

  modport slave (
    input  key_valid, key_digit, start, stop, door_closed, tmr_zero,
    output tmr_digit, tmr_load, tmr_dec, tmr_clr, mag_on, lamp, beep, state_o
  );

  modport master (
    output key_valid, key_digit, start, stop, door_closed, tmr_zero,
    input  tmr_digit, tmr_load, tmr_dec, tmr_clr, mag_on, lamp, beep, state_o
  );

endinterface

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, holds when not,
// and restarts from 0 on clr. tick flags the wrapping cycle.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next prescaler value: clear wins over counting, hold when disabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // prescaler register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en & (cnt_q == CNT_LAST);

endmodule

// File: rtl/microondas_ctrl.sv
// Microwave cooking controller: digit entry, cook/pause/done sequencing,
// door interlock, magnetron, lamp and beeper. All outputs are registered.
module microondas_ctrl
  import microondas_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int BEEP_SECS  = 3,
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic             clock,
  input  logic             reset,
  microondas_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int BEEP_W = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SECS - 1);
  localparam logic [BEEP_W-1:0] BEEP_ONE  = BEEP_W'(1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BEEP_W-1:0]  beep_cnt_q, beep_cnt_d;
  logic               first_q;
  logic [3:0]         tmr_digit_q, tmr_digit_d;
  logic               tmr_load_q, tmr_load_d;
  logic               tmr_dec_q, tmr_dec_d;
  logic               tmr_clr_q, tmr_clr_d;
  logic               mag_on_q, mag_on_d;
  logic               lamp_q, lamp_d;
  logic               beep_q, beep_d;

  logic digit_ok;
  logic pre_clr;
  logic pre_en;
  logic tick;

  assign digit_ok = bus.key_valid & is_bcd(bus.key_digit);

  // The prescaler only runs in cycles that stay in COOK or DONE, so a stop or
  // door opening freezes it and tmr_zero suppresses the final decrement.
  assign pre_en = ((state_q == ST_COOK) & ~bus.stop & bus.door_closed & ~bus.tmr_zero) |
                  ((state_q == ST_DONE) & ~bus.stop & bus.door_closed);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .tick  (tick)
  );

  // state transitions and the strobes they cause
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    beep_cnt_d  = beep_cnt_q;
    tmr_digit_d = tmr_digit_q;
    tmr_load_d  = 1'b0;
    tmr_dec_d   = 1'b0;
    tmr_clr_d   = first_q;
    pre_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (digit_ok) begin
          tmr_digit_d = bus.key_digit;
          tmr_load_d  = 1'b1;
          count_d     = CNT_ONE;
          state_d     = ST_SET;
        end else begin
          count_d = '0;
        end
      end
      ST_SET: begin
        if (bus.stop) begin
          tmr_clr_d = 1'b1;
          count_d   = '0;
          state_d   = ST_IDLE;
        end else if (bus.start) begin
          // a digit arriving with start is dropped even if start is refused
          if (bus.door_closed & ~bus.tmr_zero) begin
            state_d = ST_COOK;
            pre_clr = 1'b1;
          end else begin
            state_d = ST_SET;
          end
        end else if (digit_ok && (count_q < CNT_MAX)) begin
          tmr_digit_d = bus.key_digit;
          tmr_load_d  = 1'b1;
          count_d     = count_q + CNT_ONE;
        end else begin
          state_d = ST_SET;
        end
      end
      ST_COOK: begin
        if (bus.stop | ~bus.door_closed) begin
          state_d = ST_PAUSE;
        end else if (bus.tmr_zero) begin
          state_d    = ST_DONE;
          beep_cnt_d = '0;
          pre_clr    = 1'b1;
        end else begin
          tmr_dec_d = tick;
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          tmr_clr_d = 1'b1;
          count_d   = '0;
          state_d   = ST_IDLE;
        end else if (bus.start & bus.door_closed & ~bus.tmr_zero) begin
          state_d = ST_COOK;
          pre_clr = 1'b1;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (bus.stop | ~bus.door_closed) begin
          state_d    = ST_IDLE;
          count_d    = '0;
          beep_cnt_d = '0;
        end else if (tick) begin
          if (beep_cnt_q >= BEEP_LAST) begin
            state_d    = ST_IDLE;
            count_d    = '0;
            beep_cnt_d = '0;
          end else begin
            beep_cnt_d = beep_cnt_q + BEEP_ONE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        count_d    = '0;
        beep_cnt_d = '0;
        tmr_clr_d  = 1'b1;
      end
    endcase
    mag_on_d = (state_d == ST_COOK);
    lamp_d   = ~bus.door_closed | (state_d == ST_COOK);
    beep_d   = (state_d == ST_DONE);
  end

  // state and output registers; first_q yields the post-reset timer clear
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      beep_cnt_q  <= '0;
      first_q     <= 1'b1;
      tmr_digit_q <= 4'd0;
      tmr_load_q  <= 1'b0;
      tmr_dec_q   <= 1'b0;
      tmr_clr_q   <= 1'b0;
      mag_on_q    <= 1'b0;
      lamp_q      <= 1'b0;
      beep_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      beep_cnt_q  <= beep_cnt_d;
      first_q     <= 1'b0;
      tmr_digit_q <= tmr_digit_d;
      tmr_load_q  <= tmr_load_d;
      tmr_dec_q   <= tmr_dec_d;
      tmr_clr_q   <= tmr_clr_d;
      mag_on_q    <= mag_on_d;
      lamp_q      <= lamp_d;
      beep_q      <= beep_d;
    end
  end

  assign bus.tmr_digit = tmr_digit_q;
  assign bus.tmr_load  = tmr_load_q;
  assign bus.tmr_dec   = tmr_dec_q;
  assign bus.tmr_clr   = tmr_clr_q;
  assign bus.mag_on    = mag_on_q;
  assign bus.lamp      = lamp_q;
  assign bus.beep      = beep_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_microondas_ctrl.sv
// Bench for microondas_ctrl: vector table, directed multi-cycle sequences and
// a randomized run against a behavioural model, with a simple min:sec timer.
module tb_microondas_ctrl;

  localparam int TD = 4;
  localparam int BS = 3;

  logic clock;
  logic reset;
  logic zero_force;
  int   tval;
  int   errors;
  int   checks;

  microondas_ctrl_if bus ();

  microondas_ctrl #(.TICK_DIV(TD), .BEEP_SECS(BS), .MAX_DIGITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Timer datapath stand-in: value held as decimal mmss (e.g. 130 = 1:30).
  always @(posedge clock) begin
    if (reset || bus.tmr_clr) tval <= 0;
    else if (bus.tmr_load) tval <= (tval * 10 + int'(bus.tmr_digit)) % 1000;
    else if (bus.tmr_dec && tval != 0) tval <= (tval % 100 == 0) ? tval - 41 : tval - 1;
  end
  assign bus.tmr_zero = zero_force | (tval == 0);

  // ---------------- behavioural reference model ----------------
  int   m_state, m_cnt, m_run, m_done, m_digit;
  bit   m_first;
  logic [12:0] m_exp;

  function automatic void model_step();
    bit load, dec, clr, key_ok, dc;
    load = 0; dec = 0; clr = 0;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_run = 0; m_done = 0; m_digit = 0; m_first = 1;
      m_exp = '0;
      return;
    end
    clr = m_first; m_first = 0;
    dc = bus.door_closed;
    key_ok = bus.key_valid && (bus.key_digit <= 4'd9);
    case (m_state)
      0: if (key_ok) begin m_digit = int'(bus.key_digit); load = 1; m_cnt = 1; m_state = 1; end
      1: begin
        if (bus.stop) begin clr = 1; m_cnt = 0; m_state = 0; end
        else if (bus.start) begin
          if (dc && !bus.tmr_zero) begin m_state = 2; m_run = 0; end
        end else if (key_ok && m_cnt < 3) begin
          m_digit = int'(bus.key_digit); load = 1; m_cnt++;
        end
      end
      2: begin
        if (bus.stop || !dc) m_state = 3;
        else if (bus.tmr_zero) begin m_state = 4; m_done = 0; end
        else begin m_run++; dec = (m_run % TD == 0); end
      end
      3: begin
        if (bus.stop) begin clr = 1; m_cnt = 0; m_state = 0; end
        else if (bus.start && dc && !bus.tmr_zero) begin m_state = 2; m_run = 0; end
      end
      4: begin
        if (bus.stop || !dc) begin m_state = 0; m_cnt = 0; end
        else begin
          m_done++;
          if (m_done == BS * TD) begin m_state = 0; m_cnt = 0; end
        end
      end
      default: begin m_state = 0; clr = 1; end
    endcase
    m_exp = {3'(m_state), load, dec, clr, (m_state == 2), (!dc || m_state == 2),
             (m_state == 4), 4'(m_digit)};
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [12:0] obs();
    return {bus.state_o, bus.tmr_load, bus.tmr_dec, bus.tmr_clr, bus.mag_on,
            bus.lamp, bus.beep, bus.tmr_digit};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rs, input logic kv, input logic [3:0] kd,
                     input logic st, input logic sp, input logic dc);
    @(negedge clock);
    reset = rs; bus.key_valid = kv; bus.key_digit = kd;
    bus.start = st; bus.stop = sp; bus.door_closed = dc;
    #1;
    model_step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic rs, kv; logic [3:0] kd; logic st, sp, dc;
    logic [2:0] e_st; logic e_load; logic [3:0] e_dig; logic e_clr, e_mag, e_lamp, e_beep;
  } vec_t;

  function automatic vec_t mk(int rs, int kv, int kd, int st, int sp, int dc,
                              int es, int el, int ed, int ec, int em, int ela, int eb);
    vec_t v;
    v.rs = 1'(rs); v.kv = 1'(kv); v.kd = 4'(kd); v.st = 1'(st); v.sp = 1'(sp); v.dc = 1'(dc);
    v.e_st = 3'(es); v.e_load = 1'(el); v.e_dig = 4'(ed); v.e_clr = 1'(ec);
    v.e_mag = 1'(em); v.e_lamp = 1'(ela); v.e_beep = 1'(eb);
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    int n;
    logic door;
    logic [3:0] kd;
    errors = 0; checks = 0; zero_force = 1'b0; tval = 0;
    reset = 1'b1; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.door_closed = 1'b1;

    //            rs kv kd st sp dc   st ld dig clr mag lamp beep
    tbl[0]  = mk(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 1,   1, 1, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 3, 0, 0, 1,   1, 1, 3, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 7, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 9, 1, 1, 1,   0, 0, 0, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 12, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 15, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 5, 0, 0, 1,   1, 1, 5, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 1,   1, 0, 5, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 0, 0,   1, 0, 5, 0, 0, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 1, 1,   0, 0, 5, 1, 0, 0, 0);
    tbl[17] = mk(0, 1, 4, 1, 0, 1,   1, 1, 4, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].rs, tbl[i].kv, tbl[i].kd, tbl[i].st, tbl[i].sp, tbl[i].dc);
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'({tbl[i].e_st, tbl[i].e_load, 1'b0, tbl[i].e_clr, tbl[i].e_mag,
               tbl[i].e_lamp, tbl[i].e_beep, tbl[i].e_dig}));
    end

    // cook 1:30, decrements every TD cycles, forced zero ends in DONE
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 1, 3, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    chk("cook_state", 32'(bus.state_o), 32'd2);
    chk("cook_mag", 32'(bus.mag_on), 32'd1);
    chk("cook_dec0", 32'(bus.tmr_dec), 32'd0);
    for (int i = 1; i < 12; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk($sformatf("cook_dec%0d", i), 32'(bus.tmr_dec), 32'((i % TD) == 0));
    end
    zero_force = 1'b1;
    cyc(0, 0, 0, 0, 0, 1);
    zero_force = 1'b0;
    chk("done_state", 32'(bus.state_o), 32'd4);
    chk("done_nodec", 32'(bus.tmr_dec), 32'd0);
    chk("done_mag", 32'(bus.mag_on), 32'd0);
    n = bus.beep ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (bus.state_o != 3'd4) break;
      if (bus.beep) n++;
    end
    chk("beep_cycles", 32'(n), 32'(BS * TD));
    chk("done_exit", 32'({bus.state_o, bus.beep}), 32'd0);

    // door opened mid-cook pauses; resume restarts the prescaler
    cyc(0, 1, 2, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    chk("p_cook", 32'(bus.state_o), 32'd2);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("p_pause", 32'({bus.state_o, bus.mag_on, bus.lamp}), 32'({3'd3, 1'b0, 1'b1}));
    cyc(0, 0, 0, 1, 0, 0);
    chk("p_open_start", 32'(bus.state_o), 32'd3);
    cyc(0, 0, 0, 1, 0, 1);
    chk("p_resume", 32'({bus.state_o, bus.mag_on}), 32'({3'd2, 1'b1}));
    for (int j = 1; j <= TD; j++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk($sformatf("p_dec%0d", j), 32'(bus.tmr_dec), 32'(j == TD));
    end
    cyc(0, 0, 0, 0, 1, 1);
    chk("p_stop1", 32'(bus.state_o), 32'd3);
    cyc(0, 0, 0, 0, 1, 1);
    chk("p_stop2", 32'({bus.state_o, bus.tmr_clr}), 32'({3'd0, 1'b1}));

    // reset during cook
    cyc(0, 1, 5, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    chk("r_cook", 32'(bus.mag_on), 32'd1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("r_during", 32'({bus.state_o, bus.mag_on, bus.tmr_clr}), 32'd0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("r_clr", 32'({bus.state_o, bus.tmr_clr}), 32'({3'd0, 1'b1}));
    cyc(0, 0, 0, 0, 0, 1);
    chk("r_clr_end", 32'(bus.tmr_clr), 32'd0);

    // randomized run against the reference model
    cyc(1, 0, 0, 0, 0, 1);
    door = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) door = ~door;
      kd = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 99) < 30), kd,
          1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) < 4), door);
      chk($sformatf("rand%0d", c), 32'(obs()), 32'(m_exp));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
